is_uart_tx_feeder: RTL and testbench

- Byte buffer and launch controller directly upstream of the UART TX FSM.
- Accepts bytes from the host side on a valid/ready interface and stores them in an internal synchronous FIFO.
- Hands bytes to the TX FSM one at a time: one-cycle request strobe, then waits for the FSM's ready flag to rise before launching the next byte.
- Lets the host burst bytes without tracking frame timing.

---
 rtl/is_pkg_uart_controller.sv | 13 +
 rtl/is_uart_tx_feeder_if.sv | 23 ++
 rtl/is_sync_fifo.sv | 55 +++++
 rtl/is_uart_tx_feeder.sv | 97 +++++++++
 tb/tb_is_uart_tx_feeder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/is_pkg_uart_controller.sv
// is_pkg_uart_controller: shared UART controller types and widths.
// Also carries the TX feeder launch-state encoding.
package is_pkg_uart_controller;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STRB = 2'd1,
        WAIT = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/is_uart_tx_feeder_if.sv
// is_uart_tx_feeder_if: host write handshake plus TX FSM launch bus.
// The slave modport is the feeder; the master modport drives bytes and the TX ready flag.
interface is_uart_tx_feeder_if;
    import is_pkg_uart_controller::*;

    logic              wr_valid_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_ready_o;
    logic              tx_rdy_r_i;
    logic              tx_rdy_t_o;
    logic [DATA_W-1:0] tx_data_o;

    modport master (
        output wr_valid_i, wr_data_i, tx_rdy_r_i,
        input  wr_ready_o, tx_rdy_t_o, tx_data_o
    );

    modport slave (
        input  wr_valid_i, wr_data_i, tx_rdy_r_i,
        output wr_ready_o, tx_rdy_t_o, tx_data_o
    );

endinterface

// File: rtl/is_sync_fifo.sv
// is_sync_fifo: single-clock byte FIFO with push/pop/flush and occupancy.
// Flush wins over push and pop in the same edge; read data is the current head, unregistered.
module is_sync_fifo #(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = 8,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [PTR_W:0]    level_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    level_q, level_d;
    logic              push_ok, pop_ok;

    assign full_o  = level_q == (PTR_W+1)'(DEPTH);
    assign empty_o = level_q == '0;
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = flush_i ? wr_ptr_q : rd_ptr_q + PTR_W'(pop_ok);
        level_d  = flush_i ? '0 : level_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/is_uart_tx_feeder.sv
// is_uart_tx_feeder: byte FIFO plus one-at-a-time launch controller for the UART TX FSM.
// Optional IS_UART_TX_CTS_EN adds cts_n_i flow control on new launches.
module is_uart_tx_feeder
    import is_pkg_uart_controller::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    is_uart_tx_feeder_if.slave  bus,
    input  logic                flush_i,
`ifdef IS_UART_TX_CTS_EN
    input  logic                cts_n_i,
`endif
    output logic                busy_o,
    output logic [PTR_W:0]      level_o
);

    feeder_state_t     state_q, state_d;
    logic              strb_q, strb_d, busy_q, busy_d, rdy_q;
    logic [DATA_W-1:0] data_q, data_d, head;
    logic              full, empty, push, launch, done, cts_ok;

    assign bus.wr_ready_o = ~full & ~flush_i & ~rst_i;
    assign push           = bus.wr_valid_i & bus.wr_ready_o;
    assign done           = bus.tx_rdy_r_i & ~rdy_q;

`ifdef IS_UART_TX_CTS_EN
    logic [1:0] cts_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cts_q <= 2'b11;
        else       cts_q <= {cts_q[0], cts_n_i};
    end
    assign cts_ok = ~cts_q[1];
`else
    assign cts_ok = 1'b1;
`endif

    // a flush in the same edge suppresses the pop, so nothing is launched
    assign launch = (state_q == IDLE) & ~empty & ~flush_i & cts_ok;

    is_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (launch),
        .flush_i (flush_i),
        .wdata_i (bus.wr_data_i),
        .rdata_o (head),
        .level_o (level_o),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        strb_d  = 1'b0;
        data_d  = data_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: if (launch) begin
                state_d = STRB;
                strb_d  = 1'b1;
                data_d  = head;
                busy_d  = 1'b1;
            end
            STRB: state_d = WAIT;
            WAIT: if (done) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            strb_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            strb_q  <= strb_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            rdy_q   <= bus.tx_rdy_r_i;
        end
    end

    assign bus.tx_rdy_t_o = strb_q;
    assign bus.tx_data_o  = data_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_is_uart_tx_feeder.sv
// tb_is_uart_tx_feeder: directed/randomized bench with a queue-based reference model
// and a simple TX FSM responder that raises its ready flag a set number of cycles after each launch.
module tb_is_uart_tx_feeder;
    import is_pkg_uart_controller::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       busy;
    logic [4:0] level;
`ifdef IS_UART_TX_CTS_EN
    logic       cts_n = 1'b1;
    logic       s1, s2;
`endif

    is_uart_tx_feeder_if bus();

    is_uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus     (bus),
        .flush_i (flush),
`ifdef IS_UART_TX_CTS_EN
        .cts_n_i (cts_n),
`endif
        .busy_o  (busy),
        .level_o (level)
    );

    always #5 clk = ~clk;

    int         tests = 0, fails = 0;
    logic [7:0] q[$];
    logic       busy_m, strb_m, rdy_prev, last_acc;
    logic [7:0] data_m;
    int         cnt, lat, strobes, obs_strobes, max_lev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        q.delete();
        busy_m = 1'b0;
        strb_m = 1'b0;
        data_m = 8'h00;
        rdy_prev = 1'b0;
        cnt = 0;
        bus.tx_rdy_r_i = 1'b0;
`ifdef IS_UART_TX_CTS_EN
        s1 = 1'b1;
        s2 = 1'b1;
`endif
    endtask

    // one clock of model + checks + TX responder
    task automatic tick();
        logic done, go, acc;
        @(negedge clk);
        acc = bus.wr_valid_i && (q.size() < DEPTH) && !flush;
        chk("wr_ready", bus.wr_ready_o, (q.size() < DEPTH) && !flush);
        @(posedge clk);
        done = bus.tx_rdy_r_i && !rdy_prev;
        rdy_prev = bus.tx_rdy_r_i;
        go = !busy_m && q.size() != 0 && !flush;
`ifdef IS_UART_TX_CTS_EN
        go = go && !s2;
        s2 = s1;
        s1 = cts_n;
`endif
        if (strb_m) strb_m = 1'b0;
        else if (busy_m) begin
            if (done) busy_m = 1'b0;
        end else if (go) begin
            data_m = q.pop_front();
            strb_m = 1'b1;
            busy_m = 1'b1;
            strobes++;
        end
        if (flush) q.delete();
        if (acc) q.push_back(bus.wr_data_i);
        last_acc = acc;
        #1;
        chk("tx_rdy_t", bus.tx_rdy_t_o, strb_m);
        chk("tx_data", bus.tx_data_o, data_m);
        chk("busy", busy, busy_m);
        chk("level", level, q.size());
        if (bus.tx_rdy_t_o === 1'b1) obs_strobes++;
        if (int'(level) > max_lev) max_lev = int'(level);
        if (strb_m) begin
            bus.tx_rdy_r_i = 1'b0;
            cnt = lat;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) bus.tx_rdy_r_i = 1'b1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i = b;
        last_acc = 1'b0;
        for (int i = 0; i < 300 && !last_acc; i++) tick();
        chk("push_accepted", last_acc, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (q.size() != 0 || busy_m); i++) tick();
        chk("drained_level", level, 0);
        chk("drained_busy", busy, 1'b0);
    endtask

    initial begin
        int s;
        bus.wr_valid_i = 1'b0;
        bus.wr_data_i = 8'h00;
        strobes = 0;
        obs_strobes = 0;
        max_lev = 0;
        lat = 20;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_rdy_t", bus.tx_rdy_t_o, 0);
        chk("rst_tx_data", bus.tx_data_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_wr_ready", bus.wr_ready_o, 0);
        rst = 1'b0;
        repeat (2) tick();

        // single byte latency
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i = 8'hA5;
        tick();
        chk("a5_accepted", last_acc, 1'b1);
        bus.wr_valid_i = 1'b0;
        tick();
        chk("a5_strobe_k1", bus.tx_rdy_t_o, 1'b1);
        chk("a5_data", bus.tx_data_o, 8'hA5);
        tick();
        chk("a5_strobe_width", bus.tx_rdy_t_o, 1'b0);
        for (int i = 0; i < 40 && !bus.tx_rdy_r_i; i++) tick();
        chk("a5_busy_before_done", busy, 1'b1);
        tick();
        chk("a5_busy_clear", busy, 1'b0);
        repeat (3) tick();

        // fill to full with a slow TX FSM, then hold an extra byte until space frees
        lat = 40;
        s = obs_strobes;
        for (int b = 1; b <= 17; b++) push_byte(8'(b));
        chk("full_level", level, 16);
        bus.wr_data_i = 8'h12;
        repeat (3) tick();
        chk("full_ready_low", bus.wr_ready_o, 1'b0);
        push_byte(8'h12);
        bus.wr_valid_i = 1'b0;
        drain();
        chk("fill_strobe_count", obs_strobes - s, 18);

        // wrap-around with random gaps and random frame times
        max_lev = 0;
        for (int i = 0; i < 40; i++) begin
            lat = $urandom_range(1, 6);
            if ($urandom_range(0, 2) == 0) begin
                bus.wr_valid_i = 1'b0;
                tick();
            end
            push_byte(8'($urandom));
        end
        bus.wr_valid_i = 1'b0;
        drain();
        chk("wrap_max_level", max_lev <= DEPTH, 1'b1);

        // flush with five queued bytes while one is in flight
        lat = 30;
        for (int b = 0; b < 6; b++) push_byte(8'h60 + 8'(b));
        bus.wr_valid_i = 1'b0;
        tick();
        chk("preflush_level", level, 5);
        chk("preflush_busy", busy, 1'b1);
        s = obs_strobes;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_busy_kept", busy, 1'b1);
        for (int i = 0; i < 60 && busy; i++) tick();
        repeat (8) tick();
        chk("flush_busy_done", busy, 1'b0);
        chk("flush_no_strobe", obs_strobes - s, 0);

        // asynchronous reset mid-frame with three bytes queued
        lat = 50;
        for (int b = 0; b < 4; b++) push_byte(8'hC0 + 8'(b));
        bus.wr_valid_i = 1'b0;
        repeat (3) tick();
        chk("prerst_level", level, 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_rdy_t", bus.tx_rdy_t_o, 0);
        chk("mid_rst_tx_data", bus.tx_data_o, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_wr_ready", bus.wr_ready_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        s = obs_strobes;
        repeat (5) tick();
        chk("post_rst_ready", bus.wr_ready_o, 1'b1);
        chk("post_rst_no_strobe", obs_strobes - s, 0);

`ifdef IS_UART_TX_CTS_EN
        lat = 5;
        cts_n = 1'b1;
        s = obs_strobes;
        push_byte(8'h31);
        push_byte(8'h32);
        bus.wr_valid_i = 1'b0;
        repeat (6) tick();
        chk("cts_blocked", obs_strobes - s, 0);
        chk("cts_level", level, 2);
        cts_n = 1'b0;
        for (int i = 0; i < 3 && obs_strobes == s; i++) tick();
        chk("cts_strobe", obs_strobes - s, 1);
        drain();
`endif

        chk("total_strobes", obs_strobes, strobes);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
